// File: rtl/scan_decoder_if.sv
// Select-line bus between a controller and scan_decoder: mode/load/mask controls in, select lines and scan pulses out.
// Width of the index fields follows SIZE.
interface scan_decoder_if #(
    parameter int SIZE = 8
);
    localparam int IDX_W = $clog2(SIZE);

    logic             i_Mode;
    logic [IDX_W-1:0] i_In;
    logic             i_Load;
    logic [SIZE-1:0]  i_Mask;
    logic             i_Disable;
    logic [SIZE-1:0]  o_Out;
    logic [IDX_W-1:0] o_Index;
    logic             o_Step;
    logic             o_Wrap;

    modport master (
        output i_Mode, i_In, i_Load, i_Mask, i_Disable,
        input  o_Out, o_Index, o_Step, o_Wrap
    );

    modport slave (
        input  i_Mode, i_In, i_Load, i_Mask, i_Disable,
        output o_Out, o_Index, o_Step, o_Wrap
    );
endinterface

// File: rtl/scan_decoder.sv
// Registered one-hot select driver: direct (load-addressed) or scan (rotating, DWELL cycles per unmasked line).
// Latency 1 cycle from any input to every output; no backpressure, one decision per clock.
module scan_decoder #(
    parameter int SIZE       = 8,
    parameter int DWELL      = 4,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic           i_Clk,
    input  logic           i_Rst_n,
    scan_decoder_if.slave  bus
);
    localparam int IDX_W = $clog2(SIZE);
    localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
    localparam logic [SIZE-1:0]  INACTIVE = {SIZE{ACTIVE_LOW}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [IDX_W-1:0] r_idx;
    logic [SIZE-1:0]  r_out;
    logic             r_step;
    logic             r_wrap;

    logic [IDX_W-1:0] w_first_idx;
    logic [IDX_W-1:0] w_next_idx;
    logic             w_mask_any;
    logic             w_in_ok;
    int               w_j;

    function automatic logic [SIZE-1:0] sel_line(input logic [IDX_W-1:0] idx);
        logic [SIZE-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v ^ INACTIVE;
    endfunction

    assign w_mask_any = |bus.i_Mask;
    assign w_in_ok    = (int'(bus.i_In) < SIZE);

    always_comb begin
        w_first_idx = '0;
        for (int k = SIZE - 1; k >= 0; k--) begin
            if (bus.i_Mask[IDX_W'(k)]) w_first_idx = IDX_W'(k);
        end
    end

    // Cyclic search above r_idx; the last candidate is r_idx itself so a lone mask bit re-selects its own line.
    always_comb begin
        w_next_idx = r_idx;
        w_j        = 0;
        for (int k = SIZE; k >= 1; k--) begin
            w_j = int'(r_idx) + k;
            if (w_j >= SIZE) w_j = w_j - SIZE;
            if (bus.i_Mask[IDX_W'(w_j)]) w_next_idx = IDX_W'(w_j);
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_out   <= INACTIVE;
            r_step  <= 1'b0;
            r_wrap  <= 1'b0;
        end else begin
            r_step <= 1'b0;
            r_wrap <= 1'b0;
            if (bus.i_Disable) begin
                r_state <= IDLE;
                r_cnt   <= '0;
                r_out   <= INACTIVE;
            end else if (!bus.i_Mode) begin
                r_cnt <= '0;
                if (r_state == SCAN) begin
                    r_state <= IDLE;
                    r_out   <= INACTIVE;
                end else if (bus.i_Load) begin
                    if (w_in_ok) begin
                        r_state <= DIRECT;
                        r_idx   <= bus.i_In;
                        r_out   <= sel_line(bus.i_In);
                    end else begin
                        r_state <= IDLE;
                        r_out   <= INACTIVE;
                    end
                end
            end else if (r_state != SCAN) begin
                r_cnt <= '0;
                if (w_mask_any) begin
                    r_state <= SCAN;
                    r_idx   <= w_first_idx;
                    r_out   <= sel_line(w_first_idx);
                end else begin
                    r_state <= IDLE;
                    r_out   <= INACTIVE;
                end
            end else if (r_cnt == CNT_LAST) begin
                r_cnt <= '0;
                if (w_mask_any) begin
                    r_idx  <= w_next_idx;
                    r_out  <= sel_line(w_next_idx);
                    r_step <= 1'b1;
                    r_wrap <= (w_next_idx <= r_idx);
                end else begin
                    r_state <= IDLE;
                    r_out   <= INACTIVE;
                end
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign bus.o_Out   = r_out;
    assign bus.o_Index = r_idx;
    assign bus.o_Step  = r_step;
    assign bus.o_Wrap  = r_wrap;
endmodule

// File: tb/tb_scan_decoder.sv
// Directed checks of scan_decoder in two builds: 8 lines / dwell 4 / active-high and 5 lines / dwell 1 / active-low.
module tb_scan_decoder;
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    scan_decoder_if #(.SIZE(8)) ifa ();
    scan_decoder_if #(.SIZE(5)) ifb ();

    scan_decoder #(.SIZE(8), .DWELL(4), .ACTIVE_LOW(1'b0)) u_a (
        .i_Clk   (clk),
        .i_Rst_n (rst_n),
        .bus     (ifa)
    );

    scan_decoder #(.SIZE(5), .DWELL(1), .ACTIVE_LOW(1'b1)) u_b (
        .i_Clk   (clk),
        .i_Rst_n (rst_n),
        .bus     (ifb)
    );

    typedef struct {
        bit         b;
        logic       dis;
        logic       mode;
        logic       load;
        logic [2:0] in;
        logic [7:0] mask;
        logic [7:0] out;
        logic [2:0] idx;
        logic       step;
        logic       wrap;
    } vec_t;

    vec_t tbl[20];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_a(input string nm, input logic [7:0] out, input logic [2:0] idx,
                         input logic step, input logic wrap);
        chk({nm, "_out"},  32'(ifa.o_Out),   32'(out));
        chk({nm, "_idx"},  32'(ifa.o_Index), 32'(idx));
        chk({nm, "_step"}, 32'(ifa.o_Step),  32'(step));
        chk({nm, "_wrap"}, 32'(ifa.o_Wrap),  32'(wrap));
    endtask

    task automatic apply_vec(input int n, input vec_t v);
        string nm;
        nm = $sformatf("vec%0d", n);
        if (!v.b) begin
            ifa.i_Disable = v.dis; ifa.i_Mode = v.mode; ifa.i_Load = v.load;
            ifa.i_In = v.in;       ifa.i_Mask = v.mask;
        end else begin
            ifb.i_Disable = v.dis; ifb.i_Mode = v.mode; ifb.i_Load = v.load;
            ifb.i_In = v.in;       ifb.i_Mask = v.mask[4:0];
        end
        cyc();
        if (!v.b) begin
            chk_a(nm, v.out, v.idx, v.step, v.wrap);
        end else begin
            chk({nm, "_out"},  32'(ifb.o_Out),   32'(v.out));
            chk({nm, "_idx"},  32'(ifb.o_Index), 32'(v.idx));
            chk({nm, "_step"}, 32'(ifb.o_Step),  32'(v.step));
            chk({nm, "_wrap"}, 32'(ifb.o_Wrap),  32'(v.wrap));
        end
    endtask

    task automatic idle_inputs();
        ifa.i_Disable = 1'b0; ifa.i_Mode = 1'b0; ifa.i_Load = 1'b0; ifa.i_In = '0; ifa.i_Mask = '0;
        ifb.i_Disable = 1'b0; ifb.i_Mode = 1'b0; ifb.i_Load = 1'b0; ifb.i_In = '0; ifb.i_Mask = '0;
    endtask

    initial begin
        logic [7:0] e_out;
        int         line;
        logic       st;
        logic       wr;
        int         mlines[5];
        logic       mwrap[5];

        //          b  dis mode load in  mask   out    idx step wrap
        tbl[0]  = '{0, 0, 0, 1, 3'd5, 8'h00, 8'h20, 3'd5, 0, 0};
        tbl[1]  = '{0, 0, 0, 0, 3'd5, 8'h00, 8'h20, 3'd5, 0, 0};
        tbl[2]  = '{0, 0, 0, 1, 3'd0, 8'h00, 8'h01, 3'd0, 0, 0};
        tbl[3]  = '{0, 0, 0, 1, 3'd7, 8'h00, 8'h80, 3'd7, 0, 0};
        tbl[4]  = '{0, 1, 0, 1, 3'd3, 8'h00, 8'h00, 3'd7, 0, 0};
        tbl[5]  = '{0, 0, 0, 0, 3'd3, 8'h00, 8'h00, 3'd7, 0, 0};
        tbl[6]  = '{0, 0, 0, 1, 3'd3, 8'h00, 8'h08, 3'd3, 0, 0};
        tbl[7]  = '{1, 0, 0, 1, 3'd2, 8'h00, 8'h1B, 3'd2, 0, 0};
        tbl[8]  = '{1, 0, 0, 1, 3'd6, 8'h00, 8'h1F, 3'd2, 0, 0};
        tbl[9]  = '{1, 0, 0, 1, 3'd4, 8'h00, 8'h0F, 3'd4, 0, 0};
        tbl[10] = '{1, 0, 0, 1, 3'd5, 8'h00, 8'h1F, 3'd4, 0, 0};
        tbl[11] = '{1, 0, 0, 1, 3'd0, 8'h00, 8'h1E, 3'd0, 0, 0};
        tbl[12] = '{1, 0, 1, 0, 3'd0, 8'h04, 8'h1B, 3'd2, 0, 0};
        tbl[13] = '{1, 0, 1, 0, 3'd0, 8'h04, 8'h1B, 3'd2, 1, 1};
        tbl[14] = '{1, 0, 1, 0, 3'd0, 8'h04, 8'h1B, 3'd2, 1, 1};
        tbl[15] = '{1, 0, 1, 0, 3'd0, 8'h04, 8'h1B, 3'd2, 1, 1};
        tbl[16] = '{1, 0, 1, 0, 3'd0, 8'h05, 8'h1E, 3'd0, 1, 1};
        tbl[17] = '{1, 0, 1, 0, 3'd0, 8'h05, 8'h1B, 3'd2, 1, 0};
        tbl[18] = '{1, 1, 1, 0, 3'd0, 8'h05, 8'h1F, 3'd2, 0, 0};
        tbl[19] = '{1, 0, 1, 0, 3'd0, 8'h05, 8'h1E, 3'd0, 0, 0};

        mlines = '{0, 4, 7, 0, 4};
        mwrap  = '{0, 0, 0, 1, 0};

        idle_inputs();
        #2 rst_n = 1'b0;
        #1;
        chk_a("rst", 8'h00, 3'd0, 1'b0, 1'b0);
        chk("rst_b_out", 32'(ifb.o_Out), 32'h1F);
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        chk_a("post_rst", 8'h00, 3'd0, 1'b0, 1'b0);

        for (int i = 0; i < 20; i++) apply_vec(i, tbl[i]);

        // Asynchronous reset asserted away from any clock edge.
        #2 rst_n = 1'b0;
        #1;
        chk_a("async_rst", 8'h00, 3'd0, 1'b0, 1'b0);
        chk("async_rst_b_out", 32'(ifb.o_Out), 32'h1F);
        chk("async_rst_b_idx", 32'(ifb.o_Index), 32'h0);
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        cyc();

        ifa.i_Mode = 1'b1; ifa.i_Mask = 8'hFF;
        cyc();
        chk_a("full_entry", 8'h01, 3'd0, 1'b0, 1'b0);
        for (int c = 1; c <= 36; c++) begin
            cyc();
            line  = (c / 4) % 8;
            st    = (c % 4 == 0);
            wr    = st && (line == 0);
            e_out = 8'h01 << line;
            chk_a($sformatf("full_c%0d", c), e_out, 3'(line), st, wr);
        end

        ifa.i_Mode = 1'b0;
        cyc();
        chk_a("mode_1to0", 8'h00, 3'd1, 1'b0, 1'b0);
        ifa.i_Mode = 1'b1;
        cyc();
        chk_a("reentry", 8'h01, 3'd0, 1'b0, 1'b0);
        repeat (8) cyc();
        chk_a("pre_dis", 8'h04, 3'd2, 1'b1, 1'b0);
        ifa.i_Disable = 1'b1;
        cyc();
        chk_a("dis", 8'h00, 3'd2, 1'b0, 1'b0);
        ifa.i_Disable = 1'b0;
        cyc();
        chk_a("dis_release", 8'h01, 3'd0, 1'b0, 1'b0);
        cyc();
        ifa.i_Mode = 1'b0;
        cyc();
        chk_a("mode0_mid", 8'h00, 3'd0, 1'b0, 1'b0);
        cyc();
        chk_a("mode0_hold", 8'h00, 3'd0, 1'b0, 1'b0);
        ifa.i_Load = 1'b1; ifa.i_In = 3'd4;
        cyc();
        chk_a("mode0_load", 8'h10, 3'd4, 1'b0, 1'b0);
        ifa.i_Load = 1'b0;

        ifa.i_Mode = 1'b1; ifa.i_Mask = 8'h91;
        cyc();
        chk_a("mask_entry", 8'h01, 3'd0, 1'b0, 1'b0);
        for (int c = 1; c <= 16; c++) begin
            cyc();
            line  = mlines[c / 4];
            st    = (c % 4 == 0);
            wr    = st && mwrap[c / 4];
            e_out = 8'h01 << line;
            chk_a($sformatf("mask_c%0d", c), e_out, 3'(line), st, wr);
        end
        ifa.i_Mask = 8'h00;
        for (int c = 17; c <= 19; c++) begin
            cyc();
            chk_a($sformatf("mask0_dwell_c%0d", c), 8'h10, 3'd4, 1'b0, 1'b0);
        end
        cyc();
        chk("mask0_adv_out",  32'(ifa.o_Out),  32'h00);
        chk("mask0_adv_step", 32'(ifa.o_Step), 32'h0);
        chk("mask0_adv_wrap", 32'(ifa.o_Wrap), 32'h0);
        cyc();
        chk("mask0_idle_out", 32'(ifa.o_Out), 32'h00);
        ifa.i_Mask = 8'h91;
        cyc();
        chk_a("mask_restore", 8'h01, 3'd0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/scan_decoder.md
Name: scan_decoder

Overview:
- Registered, parametrised successor to the combinational one-hot decoder.
- Drives SIZE select lines in one of two modes: direct (load-addressed one-hot), or scan (rotating one-hot that dwells a programmable number of cycles per line and skips masked lines).
- Used for multiplexed select/strobe generation, e.g. joypad matrix select lines and chip-select sequencing.
- Supports an active-low output polarity option.

Parameters:
- SIZE, 8, number of output select lines (>=2; need not be a power of two).
- DWELL, 4, clock cycles each line stays active in scan mode (>=1).
- ACTIVE_LOW, 0, 1 inverts o_Out polarity (inactive = all ones).
- IDX_W, $clog2(SIZE), index width (localparam, derived; not overridable).

Ports:
- i_Clk  input  1  clock; all state updates on the rising edge.
- i_Rst_n  input  1  reset; asynchronous, active-low.
- i_Mode  input  1  0 = direct, 1 = scan.
- i_In  input  IDX_W  line index for direct mode.
- i_Load  input  1  direct-mode strobe; samples i_In.
- i_Mask  input  SIZE  scan enable per line; 1 = line included in the scan.
- i_Disable  input  1  synchronous force-inactive; highest priority after reset.
- o_Out  output  SIZE  registered one-hot select (polarity per ACTIVE_LOW).
- o_Index  output  IDX_W  index of the currently active line.
- o_Step  output  1  one-cycle pulse, coincident with each scan advance.
- o_Wrap  output  1  one-cycle pulse, coincident with an advance whose new index <= old index.

Behaviour:
- One clock; reset is asynchronous and active-low, on ports i_Clk and i_Rst_n.
- Reset (immediate, not clock-gated):
  - o_Out inactive (all 0, or all 1 if ACTIVE_LOW).
  - o_Index=0, o_Step=0, o_Wrap=0.
  - State IDLE, dwell counter=0.
- All outputs are registered. Latency from any input to o_Out/o_Index is exactly 1 cycle.
- States: IDLE (outputs inactive), DIRECT, SCAN.
- Priority each edge: i_Disable > mode change > load/advance.
- i_Disable=1: next cycle o_Out inactive, state IDLE, counter cleared, o_Index held, no pulses.
- Direct mode (i_Mode=0):
  - i_Load=1 with i_In<SIZE: o_Out=one-hot(i_In), o_Index=i_In, state DIRECT.
  - i_Load=1 with i_In>=SIZE: o_Out inactive, o_Index held, state IDLE.
  - No load: outputs hold.
  - o_Step and o_Wrap are always 0.
- Scan entry occurs when i_Mode=1, i_Disable=0 and state is not SCAN:
  - Select the lowest set bit of i_Mask and set counter=0.
  - Entry is not a step: no o_Step/o_Wrap pulse.
  - i_Mask==0: remain IDLE, outputs inactive, re-attempt entry every cycle.
- Scan run:
  - Counter increments each cycle.
  - When counter==DWELL-1: counter reloads to 0 and the index advances to the next set mask bit above the current index, searching cyclically (wrapping SIZE-1 -> 0).
  - o_Step=1 on the same cycle the new o_Out appears; o_Wrap=1 also if new index <= old index.
  - Only one mask bit set: the line stays active and o_Step and o_Wrap both pulse every DWELL cycles.
  - DWELL=1: advance every cycle.
- Mask handling:
  - i_Mask is sampled only at entry and at advance. A line masked mid-dwell stays active until its dwell expires.
  - i_Mask==0 at advance: o_Out inactive, state IDLE, no pulses, then the entry rule applies.
- Mode change:
  - 1->0: state IDLE, outputs inactive until the next i_Load.
  - 0->1: scan entry.
- Reset mid-scan: immediate inactive; scan restarts from entry after release if i_Mode=1.
- o_Out carries exactly one active bit in DIRECT/SCAN and zero active bits in IDLE. This invariant must never be violated.

Test Plan:
- Reset (SIZE=8, DWELL=4, ACTIVE_LOW=0): i_Rst_n low asynchronously mid-cycle -> o_Out=0x00 without waiting for an edge; o_Index=0, o_Step=0.
- Direct: mode 0, i_In=5, i_Load pulsed 1 cycle -> next edge o_Out=0x20, o_Index=5; holds 0x20 after i_Load drops. Then i_Disable=1 -> o_Out=0x00 next cycle.
- Full scan: mode 1, i_Mask=0xFF -> 0x01 for 4 cycles, then 0x02 ... 0x80, then 0x01. o_Step pulses every 4 cycles; o_Wrap pulses only on the 0x80->0x01 advance.
- Masked scan: i_Mask=0x91 -> sequence 0x01, 0x10, 0x80, 0x01 (o_Wrap pulses). Change i_Mask to 0x00 mid-dwell on 0x10 -> 0x10 held until dwell end, then 0x00. Restore 0x91 -> restarts at 0x01 with no o_Step pulse.
- Disable/mode edges: i_Disable during 0x04 -> 0x00 next cycle; release -> 0x01 (re-entry). Switch mode to 0 mid-scan -> 0x00 until i_Load.
- Polarity/range (SIZE=5, ACTIVE_LOW=1): direct i_In=2 -> o_Out=5'b11011; i_In=6 with load -> o_Out=5'b11111 and o_Index unchanged; scan with DWELL=1 and i_Mask=5'b00100 -> o_Out=5'b11011 constant, with o_Step=o_Wrap=1 every cycle.
